// File: rtl/mux4_1.sv
// mux4_1: indexed 4-to-1 word select with a combinational output and a registered copy
module mux4_1 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q
);
  logic [WIDTH-1:0] w [4];
  assign w[0] = d0;
  assign w[1] = d1;
  assign w[2] = d2;
  assign w[3] = d3;
  // an unknown index reads back all-X, so a bad sel is never masked
  assign y = w[sel];
  always_ff @(posedge clk)
    y_q <= rst ? '0 : y;
endmodule

// File: tb/tb_mux4_1.sv
// tb_mux4_1: scoreboard bench for 4- and 8-bit mux4_1 against a shift-based reference
module tb_mux4_1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] sel = 2'd0;
  logic [3:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic [7:0] e0 = '0, e1 = '0, e2 = '0, e3 = '0;
  logic [3:0] y4, yq4;
  logic [7:0] y8, yq8;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int         id;
    logic [3:0] y4;
    logic [7:0] y8;
    logic [3:0] q4;
    logic [7:0] q8;
    bit         qk;
  } exp_t;
  exp_t sb[$];

  logic [3:0] m_q4;
  logic [7:0] m_q8;
  bit m_qk = 1'b0;
  int step_id = 0;

  mux4_1 #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
                          .sel(sel), .y(y4), .y_q(yq4));
  mux4_1 #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .d0(e0), .d1(e1), .d2(e2), .d3(e3),
                          .sel(sel), .y(y8), .y_q(yq8));

  always #5 clk = ~clk;

  function automatic logic [3:0] ref4(input logic [15:0] cat, input logic [1:0] s);
    logic [15:0] t;
    t = cat >> (s * 4);
    return $isunknown(s) ? 4'bx : t[3:0];
  endfunction

  function automatic logic [7:0] ref8(input logic [31:0] cat, input logic [1:0] s);
    logic [31:0] t;
    t = cat >> (s * 8);
    return $isunknown(s) ? 8'bx : t[7:0];
  endfunction

  task automatic step(input logic r, input logic [1:0] s, input logic [15:0] c4, input logic [31:0] c8);
    exp_t e;
    @(posedge clk);
    #1;
    m_q4 = rst ? 4'd0 : ref4({d3, d2, d1, d0}, sel);
    m_q8 = rst ? 8'd0 : ref8({e3, e2, e1, e0}, sel);
    m_qk = m_qk | rst;
    rst = r;
    sel = s;
    {d3, d2, d1, d0} = c4;
    {e3, e2, e1, e0} = c8;
    e.id = step_id;
    e.y4 = ref4(c4, s);
    e.y8 = ref8(c8, s);
    e.q4 = m_q4;
    e.q8 = m_q8;
    e.qk = m_qk;
    sb.push_back(e);
    step_id++;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      if (y4 !== e.y4) begin
        n_fail++;
        $display("FAIL y4 step %0d: got %h expected %h", e.id, y4, e.y4);
      end
      n_checks++;
      if (y8 !== e.y8) begin
        n_fail++;
        $display("FAIL y8 step %0d: got %h expected %h", e.id, y8, e.y8);
      end
      if (e.qk) begin
        n_checks++;
        if (yq4 !== e.q4) begin
          n_fail++;
          $display("FAIL y_q4 step %0d: got %h expected %h", e.id, yq4, e.q4);
        end
        n_checks++;
        if (yq8 !== e.q8) begin
          n_fail++;
          $display("FAIL y_q8 step %0d: got %h expected %h", e.id, yq8, e.q8);
        end
      end
    end
  end

  initial begin
    logic [31:0] b8;
    b8 = 32'h44332211;
    step(1'b1, 2'd0, 16'hDCBA, b8);
    step(1'b1, 2'd1, 16'hDCBA, b8);
    for (int i = 0; i < 4; i++)
      step(1'b0, 2'(i), 16'hDCBA, b8);
    for (int i = 0; i < 4; i++)
      step(1'b0, 2'(i), {4'bxxxx, 4'h3, 4'hA, 4'h7}, b8);
    step(1'b0, 2'bxx, 16'h8421, b8);
    step(1'b0, 2'd1, 16'h8421, b8);
    step(1'b1, 2'd2, 16'h0500, b8);
    step(1'b1, 2'd2, 16'h0500, b8);
    step(1'b0, 2'd2, 16'h0500, b8);
    step(1'b0, 2'd0, 16'h0509, b8);
    step(1'b0, 2'd0, 16'h0509, b8);
    step(1'b0, 2'd3, 16'hF000, b8);
    step(1'b0, 2'd3, 16'hF000, b8);
    step(1'b1, 2'd3, 16'hF000, b8);
    step(1'b0, 2'd3, 16'hF000, b8);
    step(1'b0, 2'd0, 16'h1234, b8);
    for (int i = 0; i < 200; i++)
      step(($urandom_range(0, 15) == 0), 2'($urandom), 16'($urandom), $urandom);
    for (int i = 0; i < 5 && sb.size() > 0; i++)
      @(posedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mux4_1.md
# mux4_1

Parameterizable 4-to-1 multiplexer selecting one of four data words by a 2-bit index. The selected word drives a purely combinational output `y`. A registered copy `y_q` is also provided for pipelined consumers. The block is a leaf datapath element in the combinational-logic library and is instantiated wherever a small indexed word select is needed.

## Interface
Parameters:
- `WIDTH`, default 4: width in bits of each data input and of both outputs.

Ports:
- `clk`  input  1  system clock; only `y_q` uses it.
- `rst`  input  1  reset, synchronous and active-high; one clock, synchronous active-high reset.
- `d0`  input  WIDTH  data word 0.
- `d1`  input  WIDTH  data word 1.
- `d2`  input  WIDTH  data word 2.
- `d3`  input  WIDTH  data word 3.
- `sel`  input  2  index of the word to forward.
- `y`  output  WIDTH  combinational selected word.
- `y_q`  output  WIDTH  registered selected word.

## Operation
- Selection mapping for `y`:
  - `sel`=0 gives `y`=`d0`.
  - `sel`=1 gives `y`=`d1`.
  - `sel`=2 gives `y`=`d2`.
  - `sel`=3 gives `y`=`d3`.
- Implement as an index into a 4-entry word array built from `d0`..`d3`, ordered so that index i maps to `d`i.
- Isolation of unselected inputs: unselected inputs never affect `y`. This includes X or Z bits on an unselected input; `y` stays fully known when the selected input is known.
- The selected input propagates bit-exactly, including X bits. For example, if `sel`=3 and `d3` is all-X, `y` is all-X.
- If `sel` contains X or Z, `y` is all-X. This is a defined requirement, not don't-care.
- `y` has no dependence on `clk` or `rst`. Reset does not force `y`.
- `y_q` update:
  - On each rising edge of `clk`, if `rst`=1, `y_q` becomes 0.
  - Otherwise `y_q` takes the value of `y` at that edge.
- No enable and no handshake. `y_q` updates every cycle.

## Timing
- `y` is combinational, with zero cycles of latency. It is settled within the same simulation time step as any input change, with no delta-cycle ordering dependence, and is stable after a 1-time-unit settle.
- `y_q` latency is 1 cycle: the value presented at edge N appears on `y_q` after edge N.
- Reset value: `y_q` = 0 from the first rising edge with `rst`=1 until the first edge after `rst` falls. Before the first reset edge, `y_q` is undefined (X).
- Reset asserted mid-stream: the next edge clears `y_q` regardless of inputs.
- Reset deasserted: the first edge with `rst`=0 loads the current `y`.
- Simultaneous `sel` and data changes resolve combinationally. `y_q` samples only the value present at the edge.

## Test plan
- Basic select: `d0..d3`=A,B,C,D hex, `sel` swept 0,1,2,3 -> `y`=A,B,C,D in turn, each checked 1 time unit after the change with `!==`.
- Unselected X isolation: `d0`=7, `d1`=10, `d2`=3, `d3`=X:
  - `sel`=0,1,2 -> `y`=7,10,3 with no X bits.
  - `sel`=3 -> `y`=all-X.
- Unknown select: `d0..d3`=1,2,4,8 and `sel`=2'bx -> `y`=all-X. Then `sel`=1 -> `y`=2.
- Registered path: hold `rst`=1 for 2 edges -> `y_q`=0. Then release with `sel`=2 and `d2`=5 -> `y_q`=5 after the first edge with `rst`=0. Change `sel` to 0 with `d0`=9 -> `y_q`=9 one edge later, while `y`=9 immediately.
- Mid-stream reset: with `y_q`=F, assert `rst` for one edge -> `y_q`=0 while `y` still shows the selected word. Deassert `rst` -> next edge reloads `y_q`.
- Width parameter: `WIDTH`=8, `d0..d3`=11,22,33,44 hex -> `y` equals the selected full byte for every `sel`, and `y_q` follows one cycle later.
